// File: rtl/cla_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial CLA adder.
package cla_serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int NIBBLE_W = 4;

   // Nibble counter width; one bit minimum so the vector is never zero-width.
   function automatic int cnt_width(input int nib);
      return (nib > 1) ? $clog2(nib) : 1;
   endfunction

endpackage

// File: rtl/cla_serial_adder_slice.sv
// 4-bit carry look-ahead slice: generate/propagate terms with a carry-in.
module cla_slice_4bit
   import cla_serial_adder_pkg::*;
(
   input  logic [NIBBLE_W-1:0] x,
   input  logic [NIBBLE_W-1:0] y,
   input  logic                c_in,
   output logic [NIBBLE_W-1:0] s,
   output logic                c_out
);

   logic [NIBBLE_W-1:0] p;
   logic [NIBBLE_W-1:0] g;
   logic [NIBBLE_W:0]   c;

   assign p = x ^ y;
   assign g = x & y;

   // Every carry is a flat sum of products of g/p and c_in; no ripple inside the slice.
   assign c[0] = c_in;
   assign c[1] = g[0] | (p[0] & c_in);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c_in);

   assign s     = p ^ c[NIBBLE_W-1:0];
   assign c_out = c[NIBBLE_W];

endmodule

// File: rtl/cla_serial_adder.sv
// Multi-cycle WIDTH-bit adder reusing one 4-bit CLA slice per nibble, LSB first,
// with a registered carry between nibbles and a ready/valid handshake.
module cla_serial_adder
   import cla_serial_adder_pkg::*;
#(
   parameter int WIDTH = 16
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int            NIB  = WIDTH / NIBBLE_W;
   localparam int            CW   = cnt_width(NIB);
   localparam logic [CW-1:0] LAST = CW'(NIB - 1);

   state_t               state;
   state_t               state_nx;
   logic [WIDTH-1:0]     a_sh;
   logic [WIDTH-1:0]     b_sh;
   logic [WIDTH-1:0]     sum_r;
   logic                 cout_r;
   logic                 carry;
   logic [CW-1:0]        cnt;
   logic [NIBBLE_W-1:0]  nib_s;
   logic                 nib_c;

   cla_slice_4bit u_slice (
      .x     (a_sh[NIBBLE_W-1:0]),
      .y     (b_sh[NIBBLE_W-1:0]),
      .c_in  (carry),
      .s     (nib_s),
      .c_out (nib_c)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // NOTE: the default assignment first keeps this block free of inferred latches.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (in_valid)    state_nx = RUN;
         RUN:     if (cnt == LAST) state_nx = DONE;
         DONE:    if (out_ready)   state_nx = IDLE;
         default:                  state_nx = IDLE;
      endcase
   end

   // in_ready depends on state only, so a DONE->IDLE edge never also accepts.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state)
         IDLE:    in_ready  = 1'b1;
         RUN:     busy      = 1'b1;
         DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: in_ready  = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum_r  <= '0;
         cout_r <= 1'b0;
         carry  <= 1'b0;
         cnt    <= '0;
      end else begin
         unique case (state)
            IDLE: if (in_valid) begin
               carry <= cin;
               cnt   <= '0;
            end
            RUN: begin
               sum_r <= {nib_s, sum_r[WIDTH-1:NIBBLE_W]};
               carry <= nib_c;
               cnt   <= cnt + CW'(1);
               if (cnt == LAST) cout_r <= nib_c;
            end
            default: ;
         endcase
      end
   end

   // NOTE: the operand shift registers carry no reset; they are always reloaded
   // on acceptance before being consumed.
   always_ff @(posedge clk) begin
      if (state == IDLE && in_valid) begin
         a_sh <= a;
         b_sh <= b;
      end else if (state == RUN) begin
         a_sh <= {{NIBBLE_W{1'b0}}, a_sh[WIDTH-1:NIBBLE_W]};
         b_sh <= {{NIBBLE_W{1'b0}}, b_sh[WIDTH-1:NIBBLE_W]};
      end
   end

   assign sum  = sum_r;
   assign cout = cout_r;

endmodule
